bin_pack_block: RTL and testbench

BIN_PACK_BLOCK -- requirements
Module: bin_pack_block

---
 rtl/bin_pack_block.sv | 131 +++++++++++++
 tb/tb_bin_pack_block.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_pack_block.sv
// Serial-to-word packer: collects WORD_W qualified bits into a packed word or an
// XNOR popcount, then queues the result in a small FIFO with a sticky overflow flag.
module bin_pack_block #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bin_in,
    input  logic                          bin_int_in,
    input  logic                          valid_in,
    input  logic                          mode_in,
    input  logic                          out_ready,
    output logic [WORD_W-1:0]             out_data,
    output logic                          out_mode,
    output logic                          out_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CNT_W  = $clog2(WORD_W + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t              state_q;
    logic [WORD_W-1:0]   sr_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [CNT_W-1:0]    pop_cnt_q;
    logic                mode_q;

    logic [WORD_W-1:0]   sr_d;
    logic [CNT_W-1:0]    bit_cnt_d;
    logic [CNT_W-1:0]    pop_cnt_d;
    logic                mode_d;
    logic                match_bit;
    logic                push;
    logic [WORD_W-1:0]   push_word;

    logic [WORD_W:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [FCNT_W-1:0]   fifo_count_q;
    logic                overflow_q;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                wr_en;

    // The word mode is taken from mode_in only on the first bit of a word.
    always_comb begin
        mode_d    = (state_q == IDLE) ? mode_in : mode_q;
        match_bit = ~(bin_in ^ bin_int_in);
        sr_d      = {sr_q[WORD_W-2:0], bin_in};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        pop_cnt_d = pop_cnt_q + {{(CNT_W-1){1'b0}}, match_bit};
        push      = valid_in && (bit_cnt_d == CNT_W'(WORD_W));
        push_word = mode_d ? WORD_W'(pop_cnt_d) : sr_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            pop_cnt_q <= '0;
            mode_q    <= 1'b0;
        end else if (valid_in) begin
            mode_q <= mode_d;
            sr_q   <= sr_d;
            if (push) begin
                bit_cnt_q <= '0;
                pop_cnt_q <= '0;
                state_q   <= IDLE;
            end else begin
                bit_cnt_q <= bit_cnt_d;
                pop_cnt_q <= pop_cnt_d;
                state_q   <= COLLECT;
            end
        end
    end

    assign fifo_full  = (fifo_count_q == FCNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count_q == '0);
    assign pop        = !fifo_empty && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign wr_en      = push && (!fifo_full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                fifo_count_q <= fifo_count_q + FCNT_W'(1);
            end else if (!wr_en && pop) begin
                fifo_count_q <= fifo_count_q - FCNT_W'(1);
            end
            if (push && !wr_en) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; the empty-gated read below keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {mode_d, push_word};
        end
    end

    assign out_valid             = !fifo_empty;
    assign {out_mode, out_data}  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_count            = fifo_count_q;
    assign overflow              = overflow_q;

endmodule

// File: tb/tb_bin_pack_block.sv
// Directed bench for bin_pack_block: a table of single-word vectors plus
// hand-written FIFO, overflow, reset and gapped-input sequences.
module tb_bin_pack_block;

    logic       clk = 1'b0;
    logic       reset;
    logic       bin_in;
    logic       bin_int_in;
    logic       valid_in;
    logic       mode_in;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_mode;
    logic       out_valid;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_checks   = 0;
    int n_failures = 0;

    typedef struct {
        logic       mode;
        logic [7:0] data;
        logic [7:0] ref_bits;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    bin_pack_block #(.WORD_W(8), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bin_in     (bin_in),
        .bin_int_in (bin_int_in),
        .valid_in   (valid_in),
        .mode_in    (mode_in),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_mode   (out_mode),
        .out_valid  (out_valid),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_step(input logic v, input logic b, input logic r, input logic m, input logic rdy);
        valid_in   = v;
        bin_in     = b;
        bin_int_in = r;
        mode_in    = m;
        out_ready  = rdy;
        step();
        valid_in   = 1'b0;
        out_ready  = 1'b0;
    endtask

    // Sends one word MSB-first; optional idle gap after each bit, mode flip after
    // the first bit, and out_ready raised only on the final (completion) edge.
    task automatic send_word(input logic mode, input logic [7:0] d, input logic [7:0] r,
                             input bit gap, input bit flip, input bit pop_last);
        for (int i = 7; i >= 0; i--) begin
            bit_step(1'b1, d[i], r[i], (flip && i != 7) ? ~mode : mode, pop_last && i == 0);
            if (gap && i != 0) begin
                bit_step(1'b0, ~d[i], ~r[i], (flip && i != 7) ? ~mode : mode, 1'b0);
            end
        end
    endtask

    task automatic pop_expect(input string name, input logic [7:0] d, input logic m);
        check({name, " valid"}, 32'(out_valid), 32'd1);
        check({name, " data"}, 32'(out_data), 32'(d));
        check({name, " mode"}, 32'(out_mode), 32'(m));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " out_valid"}, 32'(out_valid), 32'd0);
        check({name, " out_data"}, 32'(out_data), 32'd0);
        check({name, " out_mode"}, 32'(out_mode), 32'd0);
        check({name, " fifo_count"}, 32'(fifo_count), 32'd0);
        check({name, " overflow"}, 32'(overflow), 32'd0);
    endtask

    task automatic pulse_reset(input string name);
        reset = 1'b1;
        #2;
        check_idle_outputs(name);
        reset = 1'b0;
        step();
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'hB2, 8'h00, 8'hB2};
        vecs[1] = '{1'b1, 8'hB2, 8'hB2, 8'h08};
        vecs[2] = '{1'b1, 8'hB2, 8'h00, 8'h04};
        vecs[3] = '{1'b0, 8'h00, 8'hFF, 8'h00};
        vecs[4] = '{1'b0, 8'hFF, 8'h00, 8'hFF};
        vecs[5] = '{1'b1, 8'hFF, 8'hFF, 8'h08};
        vecs[6] = '{1'b1, 8'hFF, 8'h00, 8'h00};
        vecs[7] = '{1'b1, 8'h0F, 8'hF0, 8'h00};
        vecs[8] = '{1'b1, 8'hA5, 8'hA4, 8'h07};
        vecs[9] = '{1'b0, 8'h5A, 8'h3C, 8'h5A};

        reset      = 1'b1;
        bin_in     = 1'b0;
        bin_int_in = 1'b0;
        valid_in   = 1'b0;
        mode_in    = 1'b0;
        out_ready  = 1'b0;
        #3;
        check_idle_outputs("reset");
        step();
        reset = 1'b0;
        step();

        // Completion latency: nothing visible after 7 bits, head valid after the 8th.
        for (int i = 7; i >= 1; i--) begin
            bit_step(1'b1, vecs[0].data[i], 1'b0, 1'b0, 1'b0);
        end
        check("latency 7 bits valid", 32'(out_valid), 32'd0);
        bit_step(1'b1, vecs[0].data[0], 1'b0, 1'b0, 1'b0);
        check("latency 8 bits count", 32'(fifo_count), 32'd1);
        pop_expect("latency", 8'hB2, 1'b0);
        check("latency drained", 32'(out_valid), 32'd0);

        for (int v = 0; v < 10; v++) begin
            send_word(vecs[v].mode, vecs[v].data, vecs[v].ref_bits, 1'b0, 1'b0, 1'b0);
            check($sformatf("vec%0d count", v), 32'(fifo_count), 32'd1);
            pop_expect($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].mode);
            check($sformatf("vec%0d empty data", v), 32'(out_data), 32'd0);
        end

        // out_ready while empty must not disturb anything.
        bit_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ready on empty count", 32'(fifo_count), 32'd0);

        // Overflow: five words with no consumer, fifth dropped.
        for (int w = 1; w <= 5; w++) begin
            send_word(1'b0, 8'(w * 8'h11), 8'h00, 1'b0, 1'b0, 1'b0);
            if (w == 4) check("ovf pre overflow", 32'(overflow), 32'd0);
        end
        check("ovf count", 32'(fifo_count), 32'd4);
        check("ovf flag", 32'(overflow), 32'd1);
        for (int w = 1; w <= 4; w++) begin
            pop_expect($sformatf("ovf pop%0d", w), 8'(w * 8'h11), 1'b0);
        end
        check("ovf fifth absent", 32'(out_valid), 32'd0);
        check("ovf sticky", 32'(overflow), 32'd1);
        pulse_reset("ovf reset");

        // Full FIFO with a same-edge pop on the fifth completion: no drop.
        for (int w = 1; w <= 4; w++) begin
            send_word(1'b0, 8'(w * 8'h21), 8'h00, 1'b0, 1'b0, 1'b0);
        end
        send_word(1'b1, 8'hB2, 8'h00, 1'b0, 1'b0, 1'b1);
        check("full pop count", 32'(fifo_count), 32'd4);
        check("full pop overflow", 32'(overflow), 32'd0);
        for (int w = 2; w <= 4; w++) begin
            pop_expect($sformatf("full pop%0d", w), 8'(w * 8'h21), 1'b0);
        end
        pop_expect("full pop5", 8'h04, 1'b1);
        check("full pop drained", 32'(out_valid), 32'd0);

        // Reset mid-word with a queued word: both discarded, fresh word afterwards.
        send_word(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bit_step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        pulse_reset("mid reset");
        send_word(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        check("post reset count", 32'(fifo_count), 32'd1);
        pop_expect("post reset", 8'hFF, 1'b0);

        // Gapped input with mode_in flipping after the first bit.
        send_word(1'b0, 8'hB2, 8'h00, 1'b1, 1'b1, 1'b0);
        check("gap0 count", 32'(fifo_count), 32'd1);
        pop_expect("gap0", 8'hB2, 1'b0);
        send_word(1'b1, 8'hB2, 8'hB2, 1'b1, 1'b1, 1'b0);
        pop_expect("gap1", 8'h08, 1'b1);
        check("end overflow", 32'(overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
